// File: rtl/riscv_dmem_responder_pkg.sv
// Shared RISC-V data-memory constants: MMIO address map, TXSTAT layout and helpers.
package riscv_dmem_responder_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned NUM_BYTES = XLEN / 8;

  localparam logic [XLEN-1:0] MMIO_LED_ADDR    = 32'h8000_0000;
  localparam logic [XLEN-1:0] MMIO_CYCLE_ADDR  = 32'h8000_0004;
  localparam logic [XLEN-1:0] MMIO_TXDATA_ADDR = 32'h8000_0008;
  localparam logic [XLEN-1:0] MMIO_TXSTAT_ADDR = 32'h8000_000C;
  localparam logic [XLEN-1:0] WORD_MASK        = 32'hFFFF_FFFC;

  localparam int unsigned TXSTAT_FULL_BIT  = 0;
  localparam int unsigned TXSTAT_EMPTY_BIT = 1;
  localparam int unsigned TXSTAT_OVF_BIT   = 2;
  localparam int unsigned TXSTAT_CNT_LSB   = 4;
  localparam int unsigned TXSTAT_CNT_W     = 4;

  // Where the stage-1 read result comes from.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_RAM  = 2'd1,
    SRC_MMIO = 2'd2
  } rd_src_e;

  // Word-granular match; the byte offset bits are masked out.
  function automatic logic mmio_hit(input logic [XLEN-1:0] addr,
                                    input logic [XLEN-1:0] reg_addr);
    return ((addr ^ reg_addr) & WORD_MASK) == '0;
  endfunction

  function automatic logic [XLEN-1:0] txstat_pack(input logic full,
                                                  input logic empty,
                                                  input logic ovf,
                                                  input logic [TXSTAT_CNT_W-1:0] cnt);
    logic [XLEN-1:0] v;
    v = '0;
    v[TXSTAT_FULL_BIT]  = full;
    v[TXSTAT_EMPTY_BIT] = empty;
    v[TXSTAT_OVF_BIT]   = ovf;
    v[TXSTAT_CNT_LSB +: TXSTAT_CNT_W] = cnt;
    return v;
  endfunction

endpackage

// File: rtl/riscv_byte_fifo.sv
// Byte FIFO for the TX path; a push into a full FIFO is accepted only when a pop happens in the same cycle.
module riscv_byte_fifo #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push,
  input  logic [7:0]       push_data,
  input  logic             pop,
  output logic [7:0]       head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign head_data = mem[rd_ptr];

  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Pointers and occupancy.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy gates visibility.
  always_ff @(posedge clk_in) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/riscv_dmem_responder.sv
// Data-memory responder for a RISC-V core: byte-enabled RAM plus LED/CYCLE/TX MMIO, fixed 2-cycle read latency.
module riscv_dmem_responder #(
  parameter int unsigned DEPTH      = 4096,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_addr_in,
  input  logic [31:0] mem_data_in,
  input  logic [3:0]  mem_write_enable_in,
  output logic [31:0] mem_data_out,
  output logic [15:0] led_out,
  output logic [7:0]  tx_data_out,
  output logic        tx_valid_out,
  input  logic        tx_ready_in
);

  import riscv_dmem_responder_pkg::*;

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);

  logic [AW-1:0]     ram_idx;
  logic              ram_hit;
  logic              led_hit;
  logic              cycle_hit;
  logic              txdata_hit;
  logic              txstat_hit;

  logic [XLEN-1:0]   ram [DEPTH];
  logic [XLEN-1:0]   ram_q;
  logic [XLEN-1:0]   led_q;
  logic [XLEN-1:0]   cycle_q;
  logic [XLEN-1:0]   mmio_rdata;
  logic [XLEN-1:0]   s1_mmio;
  rd_src_e           rd_src;
  rd_src_e           s1_src;

  logic              tx_push;
  logic              tx_pop;
  logic              tx_ovf_q;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FCNT_W-1:0] fifo_count;

  // Address decode.
  assign ram_idx    = mem_addr_in[AW+1:2];
  assign ram_hit    = (mem_addr_in[XLEN-1:AW+2] == '0);
  assign led_hit    = mmio_hit(mem_addr_in, MMIO_LED_ADDR);
  assign cycle_hit  = mmio_hit(mem_addr_in, MMIO_CYCLE_ADDR);
  assign txdata_hit = mmio_hit(mem_addr_in, MMIO_TXDATA_ADDR);
  assign txstat_hit = mmio_hit(mem_addr_in, MMIO_TXSTAT_ADDR);

  // Block RAM, write-first per byte lane; ram_q is the RAM's own read register.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (ram_hit && mem_write_enable_in[i]) begin
        ram[ram_idx][8*i +: 8] <= mem_data_in[8*i +: 8];
        ram_q[8*i +: 8]        <= mem_data_in[8*i +: 8];
      end else begin
        ram_q[8*i +: 8]        <= ram[ram_idx][8*i +: 8];
      end
    end
  end

  // MMIO read value uses the register state present during the request cycle.
  always_comb begin
    mmio_rdata = '0;
    rd_src     = SRC_NONE;
    if (ram_hit) begin
      rd_src = SRC_RAM;
    end else if (led_hit) begin
      rd_src     = SRC_MMIO;
      mmio_rdata = led_q;
    end else if (cycle_hit) begin
      rd_src     = SRC_MMIO;
      mmio_rdata = cycle_q;
    end else if (txstat_hit) begin
      rd_src     = SRC_MMIO;
      mmio_rdata = txstat_pack(fifo_full, fifo_empty, tx_ovf_q,
                               TXSTAT_CNT_W'(fifo_count));
    end
  end

  // Two-stage read pipeline: stage 1 tracks the source, stage 2 is the output register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_src       <= SRC_NONE;
      s1_mmio      <= '0;
      mem_data_out <= '0;
    end else begin
      s1_src  <= rd_src;
      s1_mmio <= mmio_rdata;
      case (s1_src)
        SRC_RAM:  mem_data_out <= ram_q;
        SRC_MMIO: mem_data_out <= s1_mmio;
        default:  mem_data_out <= '0;
      endcase
    end
  end

  // LED register with byte strobes.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      led_q <= '0;
    end else if (led_hit) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (mem_write_enable_in[i]) led_q[8*i +: 8] <= mem_data_in[8*i +: 8];
      end
    end
  end

  assign led_out = led_q[15:0];

  // Free-running cycle counter; writes have no effect.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) cycle_q <= '0;
    else        cycle_q <= cycle_q + 32'd1;
  end

  assign tx_push      = txdata_hit && mem_write_enable_in[0];
  assign tx_pop       = tx_ready_in && !fifo_empty;
  assign tx_valid_out = !fifo_empty;

  // Sticky overflow: a dropped push sets it, a TXSTAT byte-0 write clears it.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tx_ovf_q <= 1'b0;
    end else if (tx_push && fifo_full && !tx_pop) begin
      tx_ovf_q <= 1'b1;
    end else if (txstat_hit && mem_write_enable_in[0]) begin
      tx_ovf_q <= 1'b0;
    end
  end

  riscv_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (tx_push),
    .push_data (mem_data_in[7:0]),
    .pop       (tx_pop),
    .head_data (tx_data_out),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Scoreboard bench for riscv_dmem_responder: the driver queues expectations, a negedge monitor checks them.
module tb_riscv_dmem_responder;

  logic        clk_in;
  logic        rst_in;
  logic [31:0] mem_addr_in;
  logic [31:0] mem_data_in;
  logic [3:0]  mem_write_enable_in;
  logic [31:0] mem_data_out;
  logic [15:0] led_out;
  logic [7:0]  tx_data_out;
  logic        tx_valid_out;
  logic        tx_ready_in;

  localparam logic [31:0] A_LED    = 32'h8000_0000;
  localparam logic [31:0] A_CYCLE  = 32'h8000_0004;
  localparam logic [31:0] A_TXDATA = 32'h8000_0008;
  localparam logic [31:0] A_TXSTAT = 32'h8000_000C;
  localparam logic [31:0] A_IDLE   = 32'hF000_0000;

  // kind: 0 = mem_data_out, 1 = led_out, 2 = tx_valid_out
  typedef struct {
    int          due;
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] tx_q[$];

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   rel_cyc = 0;
  logic prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  riscv_dmem_responder dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .mem_addr_in         (mem_addr_in),
    .mem_data_in         (mem_data_in),
    .mem_write_enable_in (mem_write_enable_in),
    .mem_data_out        (mem_data_out),
    .led_out             (led_out),
    .tx_data_out         (tx_data_out),
    .tx_valid_out        (tx_valid_out),
    .tx_ready_in         (tx_ready_in)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic expect_at(input int off, input int kind, input logic [31:0] v, input string nm);
    exp_t e;
    e.due  = cyc + off;
    e.kind = kind;
    e.val  = v;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic expect_rd(input logic [31:0] v, input string nm);
    expect_at(2, 0, v, nm);
  endtask

  // Present one request for the cycle that starts at this posedge.
  task automatic cyc_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    @(posedge clk_in);
    #1;
    mem_addr_in         = a;
    mem_data_in         = d;
    mem_write_enable_in = we;
  endtask

  task automatic idle();
    cyc_req(A_IDLE, 32'h0, 4'h0);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (tx_q.size() != 0 && n < 40) begin
      idle();
      n++;
    end
    total++;
    if (tx_q.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d bytes still expected after %0d cycles, required 0", nm, tx_q.size(), n);
      tx_q.delete();
    end
  endtask

  // Monitor: due expectations, TX handshakes, and TX head stability while stalled.
  always @(negedge clk_in) begin
    logic [31:0] act;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].due <= cyc) begin
        case (exp_q[i].kind)
          0:       act = mem_data_out;
          1:       act = {16'h0, led_out};
          default: act = {31'h0, tx_valid_out};
        endcase
        if (exp_q[i].due < cyc) cmp({exp_q[i].name, "_missed"}, 32'hFFFF_FFFF, exp_q[i].val);
        else                    cmp(exp_q[i].name, act, exp_q[i].val);
        exp_q.delete(i);
      end
    end
    if (tx_valid_out && prev_hold) cmp("tx_stable", {24'h0, tx_data_out}, {24'h0, prev_data});
    if (tx_valid_out && tx_ready_in) begin
      if (tx_q.size() == 0) cmp("tx_unexpected", {24'h0, tx_data_out}, 32'hFFFF_FFFF);
      else                  cmp("tx_byte", {24'h0, tx_data_out}, {24'h0, tx_q.pop_front()});
    end
    prev_hold = tx_valid_out && !tx_ready_in;
    prev_data = tx_data_out;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in              = 1'b1;
    tx_ready_in         = 1'b0;
    mem_addr_in         = A_IDLE;
    mem_data_in         = 32'h0;
    mem_write_enable_in = 4'h0;

    idle();
    idle();
    expect_at(0, 0, 32'h0, "rst_rdata");
    expect_at(0, 1, 32'h0, "rst_led");
    expect_at(0, 2, 32'h0, "rst_txvalid");
    idle();
    rst_in  = 1'b0;
    rel_cyc = cyc;
    expect_at(1, 0, 32'h0, "post_rst_idle");

    // RAM: full write, write-first, byte write, back-to-back, range edges.
    cyc_req(32'h10, 32'hDEAD_BEEF, 4'hF);
    cyc_req(32'h10, 32'h0, 4'h0);           expect_rd(32'hDEAD_BEEF, "ram_rd");
    cyc_req(32'h20, 32'hCAFE_F00D, 4'hF);   expect_rd(32'hCAFE_F00D, "ram_write_first");
    cyc_req(32'h10, 32'h0000_00AA, 4'h1);   expect_rd(32'hDEAD_BEAA, "ram_byte_wr");
    cyc_req(32'h20, 32'h0, 4'h0);           expect_rd(32'hCAFE_F00D, "b2b_0");
    cyc_req(32'h10, 32'h0, 4'h0);           expect_rd(32'hDEAD_BEAA, "b2b_1");
    cyc_req(32'h3FFC, 32'h5566_7788, 4'hF); expect_rd(32'h5566_7788, "ram_last_word");
    cyc_req(32'h4010, 32'h1111_1111, 4'hF); expect_rd(32'h0, "ram_oor_wr");
    cyc_req(32'h4000, 32'h0, 4'h0);         expect_rd(32'h0, "ram_oor_rd");
    cyc_req(32'h10, 32'h0, 4'h0);           expect_rd(32'hDEAD_BEAA, "ram_no_alias");
    cyc_req(32'h3FFC, 32'h0, 4'h0);         expect_rd(32'h5566_7788, "ram_last_rd");

    // CYCLE: consecutive reads, write ignored.
    cyc_req(A_CYCLE, 32'hFFFF_FFFF, 4'hF);  expect_rd(32'(cyc - rel_cyc), "cycle_0");
    cyc_req(A_CYCLE, 32'h0, 4'h0);          expect_rd(32'(cyc - rel_cyc), "cycle_1");

    // LED and unmapped space.
    cyc_req(A_LED, 32'h0000_1234, 4'hF);
    cyc_req(32'h9000_0000, 32'h0, 4'h0);    expect_rd(32'h0, "unmapped_rd");
    expect_at(0, 1, 32'h0000_1234, "led_out");
    cyc_req(A_LED, 32'hFFFF_FFFF, 4'h2);
    cyc_req(A_LED, 32'h0, 4'h0);            expect_rd(32'h0000_FF34, "led_strobe_rd");
    expect_at(0, 1, 32'h0000_FF34, "led_out_strobe");
    cyc_req(A_TXDATA, 32'h0, 4'h0);         expect_rd(32'h0, "txdata_rd_zero");

    // TX: overflow on a stalled consumer, then drain in order.
    cyc_req(A_TXSTAT, 32'h0, 4'h0);         expect_rd(32'h02, "txstat_empty");
    for (int i = 1; i <= 5; i++) begin
      cyc_req(A_TXDATA, 32'(i), 4'h1);
      if (i <= 4) tx_q.push_back(8'(i));
      if (i == 1) expect_at(1, 2, 32'h1, "tx_valid_set");
    end
    cyc_req(A_TXSTAT, 32'h0, 4'h0);         expect_rd(32'h45, "txstat_full_ovf");
    idle();
    tx_ready_in = 1'b1;
    drain("tx_drain_ovf");
    cyc_req(A_TXSTAT, 32'h1, 4'h1);         expect_rd(32'h06, "txstat_ovf_sticky");
    cyc_req(A_TXSTAT, 32'h0, 4'h0);         expect_rd(32'h02, "txstat_ovf_clr");

    // TX: push into a full FIFO while it pops is accepted.
    for (int i = 0; i < 4; i++) begin
      cyc_req(A_TXDATA, 32'(8'h11 + i), 4'h1);
      tx_ready_in = 1'b0;
      tx_q.push_back(8'(8'h11 + i));
    end
    cyc_req(A_TXDATA, 32'h15, 4'h1);
    tx_ready_in = 1'b1;
    tx_q.push_back(8'h15);
    cyc_req(A_TXSTAT, 32'h0, 4'h0);         expect_rd(32'h41, "txstat_full_pop");
    drain("tx_drain_full_pop");
    cyc_req(A_TXSTAT, 32'h0, 4'h0);         expect_rd(32'h02, "txstat_final");

    // Reset with reads in flight: output clears at once, RAM survives.
    cyc_req(A_TXDATA, 32'h77, 4'h1);
    tx_ready_in = 1'b0;
    cyc_req(32'h10, 32'h0, 4'h0);           expect_rd(32'hDEAD_BEAA, "pre_rst_rd");
    cyc_req(32'h10, 32'h0, 4'h0);
    cyc_req(32'h10, 32'h0, 4'h0);
    idle();
    rst_in = 1'b1;
    expect_at(0, 0, 32'h0, "rst_async_rdata");
    expect_at(0, 1, 32'h0, "rst_async_led");
    expect_at(0, 2, 32'h0, "rst_async_txvalid");
    idle();
    cyc_req(32'h10, 32'h0, 4'h0);
    rst_in  = 1'b0;
    rel_cyc = cyc;
    expect_rd(32'hDEAD_BEAA, "ram_retained");
    expect_at(1, 0, 32'h0, "rst_pipe_clear");
    tx_ready_in = 1'b1;
    cyc_req(A_CYCLE, 32'h0, 4'h0);          expect_rd(32'(cyc - rel_cyc), "cycle_after_rst");
    cyc_req(A_TXSTAT, 32'h0, 4'h0);         expect_rd(32'h02, "txstat_after_rst");

    repeat (4) idle();
    cmp("pending_expectations", 32'(exp_q.size() + tx_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_dmem_responder.md
RISCV_DMEM_RESPONDER -- requirements
Module: riscv_dmem_responder

Interface
REQ-001 Parameter DEPTH, default 4096, number of 32-bit RAM words (power of two).
REQ-002 Parameter FIFO_DEPTH, default 4, TX byte FIFO entries (power of two).
REQ-003 clk_in  input  1  single clock; all state updates on posedge.
REQ-004 rst_in  input  1  reset; asynchronous and active-high.
REQ-005 mem_addr_in  input  32  byte address from core dmem port; word select = [31:2].
REQ-006 mem_data_in  input  32  write data from core.
REQ-007 mem_write_enable_in  input  4  per-byte write strobes; bit i covers bits [8i+7:8i].
REQ-008 mem_data_out  output  32  read data, fixed 2-cycle latency.
REQ-009 led_out  output  16  LED register, low 16 bits.
REQ-010 tx_data_out  output  8  head byte of TX FIFO.
REQ-011 tx_valid_out  output  1  FIFO non-empty.
REQ-012 tx_ready_in  input  1  consumer accepts byte when high with tx_valid_out.

Function
REQ-013 Every cycle is a read request; no read enable exists.
REQ-014 Address map: RAM 0x0000_0000..DEPTH*4-1; LED 0x8000_0000 R/W; CYCLE 0x8000_0004 RO; TXDATA 0x8000_0008 WO; TXSTAT 0x8000_000C R/W.
REQ-015 Data for a request presented in cycle N SHALL appear on mem_data_out in cycle N+2, for RAM and MMIO alike.
REQ-016 Writes SHALL commit at the posedge ending cycle N, byte-masked by mem_write_enable_in.
REQ-017 A read and write to the same RAM word in cycle N SHALL return the newly written data (write-first).
REQ-018 Back-to-back requests SHALL be accepted every cycle with no stall.
REQ-019 LED register SHALL honour byte strobes; led_out = LED[15:0].
REQ-020 CYCLE SHALL be a 32-bit free-running counter incrementing each cycle, wrapping 0xFFFF_FFFF -> 0; writes ignored.
REQ-021 A write to TXDATA with strobe bit 0 set SHALL push mem_data_in[7:0].
REQ-022 TXSTAT read value: bit0 full, bit1 empty, bit2 sticky overflow, bits[7:4] count, rest 0; reflects state sampled in cycle N.
REQ-023 Push when full and no pop in same cycle SHALL be dropped and set overflow.
REQ-024 Push when full with simultaneous pop SHALL be accepted; count unchanged.
REQ-025 Pop occurs when tx_valid_out and tx_ready_in; tx_data_out SHALL be stable while tx_valid_out high and tx_ready_in low.
REQ-026 Any write to TXSTAT with strobe bit 0 set SHALL clear overflow.
REQ-027 Unmapped (and RAM out-of-range) reads SHALL return 0; writes SHALL be ignored.

Reset
REQ-028 During rst_in: mem_data_out=0, read pipeline cleared, LED=0, CYCLE=0, FIFO empty, overflow=0, tx_valid_out=0.
REQ-029 RAM contents SHALL NOT be cleared by reset.
REQ-030 Reset mid-operation SHALL discard in-flight reads; first valid data appears 2 cycles after the first post-reset request.

Structure
REQ-031 Address-map constants and TXSTAT bit positions SHALL live in the shared RISC-V constants file.
REQ-032 TX FIFO SHALL be sub-module riscv_byte_fifo (push/pop/full/empty/count).
REQ-033 RAM SHALL be inferable as block RAM with byte enables plus one output register stage.

Verification
REQ-034 Write 0xDEADBEEF to 0x10 strobe 0xF, then read 0x10 -> 0xDEADBEEF two cycles after the read request.
REQ-035 Write 0x000000AA to 0x10 strobe 0x1 over 0xDEADBEEF -> read returns 0xDEADBEAA.
REQ-036 Read CYCLE in two consecutive cycles -> values differ by exactly 1.
REQ-037 tx_ready_in=0; push 5 bytes 0x01..0x05 -> TXSTAT=0x45 (full, overflow, count 4); release ready -> bytes 0x01..0x04 in order.
REQ-038 Write 0x1234 to LED then read 0x9000_0000 -> led_out=0x1234, read returns 0.
REQ-039 Assert rst_in with a read pending -> mem_data_out=0 immediately; RAM word at 0x10 retained after reset.
